// File: rtl/conv_pkg.sv
// Shared constants, bank selects and FSM states for the convolution host memory.
package conv_pkg;

    localparam int unsigned DW   = 20;
    localparam int unsigned IAW  = 12;
    localparam int unsigned L1AW = 10;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/conv_host_mem_if.sv
// Accelerator-facing memory bus: start handshake, image read port, layer read/write ports.
interface conv_host_mem_if
    import conv_pkg::*;
#(
    parameter int unsigned DW  = conv_pkg::DW,
    parameter int unsigned IAW = conv_pkg::IAW
);

    logic           ready;
    logic           busy;
    logic [IAW-1:0] iaddr;
    logic [DW-1:0]  idata;
    logic           crd;
    logic [IAW-1:0] caddr_rd;
    logic [DW-1:0]  cdata_rd;
    logic           cwr;
    logic [IAW-1:0] caddr_wr;
    logic [DW-1:0]  cdata_wr;
    logic [2:0]     csel;

    // master = accelerator, slave = host memory
    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

endinterface

// File: rtl/conv_sram_1w1r.sv
// Storage array: one synchronous write port, two asynchronous read ports.
module conv_sram_1w1r #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 20,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents on a same-cycle collision.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/conv_host_mem.sv
// Host end of the accelerator memory protocol: image/L0/L1 stores, start handshake,
// write/run counters and sticky protocol error.
module conv_host_mem
    import conv_pkg::*;
#(
    parameter int unsigned DW      = conv_pkg::DW,
    parameter int unsigned IAW     = conv_pkg::IAW,
    parameter int unsigned L1AW    = conv_pkg::L1AW,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             img_we,
    input  logic [IAW-1:0]   img_waddr,
    input  logic [DW-1:0]    img_wdata,
    input  logic             start,
    output logic             done,
    output logic             err,
    output logic [31:0]      run_cycles,
    output logic [IAW:0]     l0_wr_cnt,
    output logic [L1AW:0]    l1_wr_cnt,
    input  logic [1:0]       dump_sel,
    input  logic [IAW-1:0]   dump_addr,
    output logic [DW-1:0]    dump_data,
    conv_host_mem_if.slave   acc
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     run_q, run_d, run_base;
    logic [IAW:0]    l0_cnt_q, l0_cnt_d, l0_base;
    logic [L1AW:0]   l1_cnt_q, l1_cnt_d, l1_base;
    logic            err_q, err_d;
    logic            clr, run_inc, tmo_err;

    logic            sel_l0, sel_l1, l1_addr_ok, img_ok;
    logic            l0_we, l1_we, img_wen, err_evt;
    logic [DW-1:0]   img_rd_acc, img_rd_dump, l0_rd_acc, l0_rd_dump, l1_rd_acc, l1_rd_dump;

    assign sel_l0     = (acc.csel == CSEL_L0);
    assign sel_l1     = (acc.csel == CSEL_L1);
    assign l1_addr_ok = (acc.caddr_wr[IAW-1:L1AW] == '0);
    assign img_ok     = (state_q == IDLE) || (state_q == DONE);

    assign l0_we   = acc.cwr & sel_l0;
    assign l1_we   = acc.cwr & sel_l1 & l1_addr_ok;
    assign img_wen = img_we & img_ok;

    assign err_evt = (acc.cwr & ~sel_l0 & ~sel_l1)
                   | (acc.cwr & sel_l1 & ~l1_addr_ok)
                   | (acc.crd & ~sel_l0 & ~sel_l1)
                   | (img_we & ~img_ok);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        clr     = 1'b0;
        run_inc = 1'b0;
        tmo_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    tmo_d   = '0;
                    clr     = 1'b1;
                end
            end
            ARM: begin
                // The busy edge that ends ARM is the first busy cycle of the run.
                if (acc.busy) begin
                    state_d = RUN;
                    run_inc = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    tmo_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RUN: begin
                if (acc.busy) begin
                    run_inc = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters restart from zero on start, then saturate.
    always_comb begin
        run_base = clr ? '0 : run_q;
        l0_base  = clr ? '0 : l0_cnt_q;
        l1_base  = clr ? '0 : l1_cnt_q;
        run_d    = (run_inc && run_base != '1) ? run_base + 1'b1 : run_base;
        l0_cnt_d = (l0_we && l0_base != '1) ? l0_base + 1'b1 : l0_base;
        l1_cnt_d = (l1_we && l1_base != '1) ? l1_base + 1'b1 : l1_base;
        err_d    = (clr ? 1'b0 : err_q) | err_evt | tmo_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            run_q    <= '0;
            l0_cnt_q <= '0;
            l1_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            run_q    <= run_d;
            l0_cnt_q <= l0_cnt_d;
            l1_cnt_q <= l1_cnt_d;
            err_q    <= err_d;
        end
    end

    assign acc.ready  = (state_q == ARM);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign run_cycles = run_q;
    assign l0_wr_cnt  = l0_cnt_q;
    assign l1_wr_cnt  = l1_cnt_q;

    conv_sram_1w1r #(.DEPTH(1 << IAW), .WIDTH(DW)) u_img (
        .clk     (clk),
        .we      (img_wen),
        .waddr   (img_waddr),
        .wdata   (img_wdata),
        .raddr_a (acc.iaddr),
        .rdata_a (img_rd_acc),
        .raddr_b (dump_addr),
        .rdata_b (img_rd_dump)
    );

    conv_sram_1w1r #(.DEPTH(1 << IAW), .WIDTH(DW)) u_l0 (
        .clk     (clk),
        .we      (l0_we),
        .waddr   (acc.caddr_wr),
        .wdata   (acc.cdata_wr),
        .raddr_a (acc.caddr_rd),
        .rdata_a (l0_rd_acc),
        .raddr_b (dump_addr),
        .rdata_b (l0_rd_dump)
    );

    conv_sram_1w1r #(.DEPTH(1 << L1AW), .WIDTH(DW)) u_l1 (
        .clk     (clk),
        .we      (l1_we),
        .waddr   (acc.caddr_wr[L1AW-1:0]),
        .wdata   (acc.cdata_wr),
        .raddr_a (acc.caddr_rd[L1AW-1:0]),
        .rdata_a (l1_rd_acc),
        .raddr_b (dump_addr[L1AW-1:0]),
        .rdata_b (l1_rd_dump)
    );

    assign acc.idata = img_rd_acc;

    always_comb begin
        acc.cdata_rd = '0;
        if (sel_l0) begin
            acc.cdata_rd = l0_rd_acc;
        end else if (sel_l1) begin
            acc.cdata_rd = l1_rd_acc;
        end
    end

    always_comb begin
        dump_data = '0;
        unique case (dump_sel)
            2'd0:    dump_data = img_rd_dump;
            2'd1:    dump_data = l0_rd_dump;
            2'd2:    dump_data = l1_rd_dump;
            default: dump_data = '0;
        endcase
    end

endmodule

// File: tb/tb_conv_host_mem.sv
// Self-checking bench for conv_host_mem: directed protocol scenarios plus randomized traffic
// checked against a store/counter reference model.
module tb_conv_host_mem;
    import conv_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset, img_we, start, done, err;
    logic [11:0] img_waddr, dump_addr;
    logic [19:0] img_wdata, dump_data;
    logic [31:0] run_cycles;
    logic [12:0] l0_wr_cnt;
    logic [10:0] l1_wr_cnt;
    logic [1:0]  dump_sel;

    conv_host_mem_if acc ();

    conv_host_mem #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .img_we     (img_we),
        .img_waddr  (img_waddr),
        .img_wdata  (img_wdata),
        .start      (start),
        .done       (done),
        .err        (err),
        .run_cycles (run_cycles),
        .l0_wr_cnt  (l0_wr_cnt),
        .l1_wr_cnt  (l1_wr_cnt),
        .dump_sel   (dump_sel),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .acc        (acc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    // Reference model: sparse stores, counters, sticky error, run flag.
    logic [19:0] img_m [int];
    logic [19:0] l0_m  [int];
    logic [19:0] l1_m  [int];
    int          l0_n, l1_n;
    bit          err_m, in_run;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic img_wr(input logic [11:0] a, input logic [19:0] d);
        img_we = 1'b1; img_waddr = a; img_wdata = d;
        @(negedge clk);
        if (!in_run) img_m[int'(a)] = d;
        else err_m = 1'b1;
        tick();
        img_we = 1'b0;
    endtask

    task automatic acc_op(input logic rd, input logic wr, input logic [2:0] sel,
                          input logic [11:0] ra, input logic [11:0] wa, input logic [19:0] wd);
        acc.crd = rd; acc.cwr = wr; acc.csel = sel;
        acc.caddr_rd = ra; acc.caddr_wr = wa; acc.cdata_wr = wd;
        @(negedge clk);
        if (rd) begin
            if (sel == CSEL_L0) begin
                if (l0_m.exists(int'(ra))) check_eq("cdata_l0", 32'(acc.cdata_rd), 32'(l0_m[int'(ra)]));
            end else if (sel == CSEL_L1) begin
                if (l1_m.exists(int'(ra) % 1024))
                    check_eq("cdata_l1", 32'(acc.cdata_rd), 32'(l1_m[int'(ra) % 1024]));
            end else begin
                check_eq("cdata_none", 32'(acc.cdata_rd), 32'd0);
                err_m = 1'b1;
            end
        end
        if (wr) begin
            if (sel == CSEL_L0) begin
                l0_m[int'(wa)] = wd;
                if (l0_n < 8191) l0_n++;
            end else if (sel == CSEL_L1 && wa < 12'd1024) begin
                l1_m[int'(wa)] = wd;
                if (l1_n < 2047) l1_n++;
            end else begin
                err_m = 1'b1;
            end
        end
        tick();
        acc.crd = 1'b0; acc.cwr = 1'b0;
    endtask

    task automatic dump_chk(input string tag, input logic [1:0] s, input logic [11:0] a,
                            input logic [19:0] exp);
        dump_sel = s; dump_addr = a;
        #1;
        check_eq(tag, 32'(dump_data), 32'(exp));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        err_m = 1'b0; l0_n = 0; l1_n = 0; in_run = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, base, nb;
        logic [2:0] sel_tab [8];
        logic [2:0] s;
        logic [11:0] wa;
        sel_tab = '{CSEL_L0, CSEL_L1, CSEL_L0, CSEL_L1, 3'b010, CSEL_NONE, 3'b111, CSEL_L1};
        reset = 1'b1; img_we = 1'b0; img_waddr = '0; img_wdata = '0; start = 1'b0;
        dump_sel = 2'd3; dump_addr = '0;
        acc.busy = 1'b0; acc.iaddr = '0; acc.crd = 1'b0; acc.caddr_rd = '0;
        acc.cwr = 1'b0; acc.caddr_wr = '0; acc.cdata_wr = '0; acc.csel = CSEL_NONE;
        l0_n = 0; l1_n = 0; err_m = 1'b0; in_run = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_ready", 32'(acc.ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_run", run_cycles, 32'd0);
        check_eq("rst_l0cnt", 32'(l0_wr_cnt), 32'd0);
        check_eq("rst_l1cnt", 32'(l1_wr_cnt), 32'd0);
        dump_chk("dump_none", 2'd3, 12'd0, 20'd0);

        // Image load and wrap
        img_wr(12'd0, 20'h0ABCD);
        img_wr(12'd4031, 20'h00777);
        acc.iaddr = 12'd0; #1;
        check_eq("idata_0", 32'(acc.idata), 32'h0ABCD);
        acc.iaddr = 12'hFBF; #1;
        check_eq("idata_fbf", 32'(acc.idata), 32'h00777);

        // Bank separation
        acc_op(1'b0, 1'b1, CSEL_L0, 12'd0, 12'd5, 20'h12345);
        acc_op(1'b0, 1'b1, CSEL_L1, 12'd0, 12'd5, 20'h00ABC);
        acc_op(1'b1, 1'b0, CSEL_L0, 12'd5, 12'd0, 20'd0);
        acc_op(1'b1, 1'b0, CSEL_L1, 12'd5, 12'd0, 20'd0);
        check_eq("bank_l0cnt", 32'(l0_wr_cnt), 32'd1);
        check_eq("bank_l1cnt", 32'(l1_wr_cnt), 32'd1);

        // Illegal select, then start clears err
        acc_op(1'b0, 1'b1, CSEL_L0, 12'd0, 12'd7, 20'h11111);
        acc_op(1'b0, 1'b1, CSEL_L1, 12'd0, 12'd7, 20'h22222);
        acc_op(1'b0, 1'b1, 3'b010, 12'd0, 12'd7, 20'hFFFFF);
        check_eq("ill_err", 32'(err), 32'd1);
        dump_chk("ill_l0", 2'd1, 12'd7, 20'h11111);
        dump_chk("ill_l1", 2'd2, 12'd7, 20'h22222);
        check_eq("ill_l0cnt", 32'(l0_wr_cnt), 32'd2);
        check_eq("ill_l1cnt", 32'(l1_wr_cnt), 32'd2);
        base = done_seen;
        do_start();
        check_eq("start_err_clr", 32'(err), 32'd0);
        check_eq("start_ready", 32'(acc.ready), 32'd1);
        check_eq("start_l0cnt_clr", 32'(l0_wr_cnt), 32'd0);

        // Handshake: 100 busy cycles
        acc.busy = 1'b1;
        tick();
        check_eq("busy_ready_fall", 32'(acc.ready), 32'd0);
        for (int i = 1; i < 100; i++) tick();
        acc.busy = 1'b0;
        tick();
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("run_100", run_cycles, 32'd100);
        tick();
        in_run = 1'b0;
        check_eq("done_low", 32'(done), 32'd0);
        check_eq("done_count", 32'(done_seen - base), 32'd1);

        // Timeout
        base = done_seen;
        do_start();
        n = 0;
        while (acc.ready === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        in_run = 1'b0;
        check_eq("tmo_cycles", 32'(n), 32'(TMO));
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_state", 32'(dut.state_q), 32'(IDLE));
        tick(); tick();
        check_eq("tmo_no_done", 32'(done_seen - base), 32'd0);

        // Randomized traffic through a full run
        for (int i = 0; i < 8; i++) img_wr(12'($urandom_range(0, 4095)), 20'($urandom));
        do_start();
        acc.busy = 1'b1;
        nb = 300;
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                img_wr(12'($urandom_range(0, 4095)), 20'($urandom));
            end else begin
                s  = sel_tab[$urandom_range(0, 7)];
                wa = 12'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) wa = wa | 12'h400;
                acc_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
                       12'($urandom_range(0, 15)), wa, 20'($urandom));
            end
        end
        acc.busy = 1'b0;
        tick();
        check_eq("rnd_done", 32'(done), 32'd1);
        check_eq("rnd_run", run_cycles, 32'(nb));
        check_eq("rnd_err", 32'(err), 32'(err_m));
        check_eq("rnd_l0cnt", 32'(l0_wr_cnt), 32'(l0_n));
        check_eq("rnd_l1cnt", 32'(l1_wr_cnt), 32'(l1_n));
        tick();
        in_run = 1'b0;
        foreach (l0_m[k]) dump_chk("rnd_dump_l0", 2'd1, 12'(k), l0_m[k]);
        foreach (l1_m[k]) dump_chk("rnd_dump_l1", 2'd2, 12'(k), l1_m[k]);
        foreach (img_m[k]) begin
            dump_chk("rnd_dump_img", 2'd0, 12'(k), img_m[k]);
            acc.iaddr = 12'(k); #1;
            check_eq("rnd_idata", 32'(acc.idata), 32'(img_m[k]));
        end

        // Reset mid-RUN
        do_start();
        acc.busy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i % 5 == 0) acc_op(1'b0, 1'b1, CSEL_L0, 12'd0, 12'(100 + i / 5), 20'($urandom));
            else acc_op(1'b0, 1'b0, CSEL_NONE, 12'd0, 12'd0, 20'd0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; acc.busy = 1'b0; in_run = 1'b0;
        check_eq("rr_ready", 32'(acc.ready), 32'd0);
        check_eq("rr_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rr_l0cnt", 32'(l0_wr_cnt), 32'd0);
        check_eq("rr_run", run_cycles, 32'd0);
        for (int i = 0; i < 10; i++) dump_chk("rr_dump_l0", 2'd1, 12'(100 + i), l0_m[100 + i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
